// File: rtl/booth4_pkg.sv
// Shared Booth radix-4 types and width helpers.
// Used by the sequential CSA multiplier and the Wallace-tree multiplier.
package booth4_pkg;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG2,
    NEG1
  } digit_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINAL,
    DONE
  } state_t;

  function automatic int pw_of(input int w);
    return 2 * w;
  endfunction

  function automatic int digits_of(input int w);
    return w / 2;
  endfunction

  function automatic digit_t booth_dec(input logic [2:0] t);
    digit_t d;
    d = ZERO;
    unique case (t)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth4_csa_seq_mult_pp_sel.sv
// Radix-4 Booth partial-product selector (combinational).
// Picks 0/+-A/+-2A at product width and aligns it to digit k.
module booth4_pp_sel
  import booth4_pkg::*;
#(
  parameter int PW = 32,
  parameter int KW = 3
) (
  input  logic [2:0]    bits,
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] na,
  input  logic [KW-1:0] k,
  output logic [PW-1:0] pp
);

  digit_t        d;
  logic [PW-1:0] sel;

  always_comb begin
    d   = booth_dec(bits);
    sel = '0;
    unique case (1'b1)
      (d == POS1): sel = a;
      (d == POS2): sel = a << 1;
      (d == NEG2): sel = na << 1;
      (d == NEG1): sel = na;
      default:     sel = '0;
    endcase
    pp = sel << {k, 1'b0};
  end

endmodule

// File: rtl/compressor_3_2.sv
// Full-adder cell used as a 3:2 carry-save compressor.
// One instance per product bit in the accumulator row.
module compressor_3_2 (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/booth4_csa_seq_mult.sv
// Iterative radix-4 Booth multiplier, one PP per cycle into a CSA.
// Optional EARLY_TERM_EN stops once the remaining multiplier bits are sign.
module booth4_csa_seq_mult
  import booth4_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int PW     = pw_of(WIDTH);
  localparam int DIGITS = digits_of(WIDTH);
  localparam int KW     = $clog2(DIGITS);

  state_t        state, state_n;
  logic [PW-1:0] a_q, na_q, s_q;
  logic [PW-2:0] c_q;
  logic [WIDTH:0] b_q, b_sh;
  logic [KW-1:0] k_q;
  logic [PW-1:0] pp, cs, s_n, c_n, sum, a_ext;
  logic          accept, last;
  logic          unused_carry;

  assign accept   = in_valid & in_ready;
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  assign a_ext = {{WIDTH{in_a[WIDTH-1]}}, in_a};
  assign cs    = {c_q, 1'b0};
  assign sum   = s_q + cs;
  assign b_sh  = $signed(b_q) >>> 2;

  // The carry out of the top bit is beyond the product width.
  assign unused_carry = c_n[PW-1];

`ifdef EARLY_TERM_EN
  assign last = (k_q == KW'(DIGITS - 1))
              | (&b_sh) | (~|b_sh);
`else
  assign last = (k_q == KW'(DIGITS - 1));
`endif

  booth4_pp_sel #(
    .PW(PW),
    .KW(KW)
  ) u_pp_sel (
    .bits(b_q[2:0]),
    .a   (a_q),
    .na  (na_q),
    .k   (k_q),
    .pp  (pp)
  );

  for (genvar i = 0; i < PW; i++) begin : g_csa
    compressor_3_2 u_csa (
      .x(s_q[i]),
      .y(cs[i]),
      .z(pp[i]),
      .s(s_n[i]),
      .c(c_n[i])
    );
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (accept) state_n = RUN;
      RUN:   if (last) state_n = FINAL;
      FINAL: state_n = DONE;
      DONE:  if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      a_q       <= '0;
      na_q      <= '0;
      b_q       <= '0;
      s_q       <= '0;
      c_q       <= '0;
      k_q       <= '0;
      out_p     <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          a_q  <= a_ext;
          na_q <= -a_ext;
          b_q  <= {in_b, 1'b0};
          s_q  <= '0;
          c_q  <= '0;
          k_q  <= '0;
        end
        RUN: begin
          s_q <= s_n;
          c_q <= c_n[PW-2:0];
          b_q <= b_sh;
          k_q <= k_q + KW'(1);
        end
        FINAL: begin
          out_p     <= sum;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
